// File: rtl/module_memory_ctrl_pkg.sv
// Shared definitions for the memory controller slice: FSM state encoding,
// legal read-latency range, lane-count derivation and a parameter legality
// predicate evaluated at elaboration by the blocks that import it.
package memory_defs;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  localparam int unsigned LAT_MIN = 1;
  localparam int unsigned LAT_MAX = 2;

  // Number of independently writable lanes in one word.
  function automatic int unsigned lanes_of(input int unsigned dw, input int unsigned bw);
    return dw / bw;
  endfunction

  function automatic bit params_legal(input int unsigned dw, input int unsigned bw,
                                      input int unsigned lat);
    return (bw != 0) && (dw >= bw) && ((dw % bw) == 0) && (lat >= LAT_MIN) && (lat <= LAT_MAX);
  endfunction

endpackage

// File: rtl/module_memory_ctrl_array.sv
// Byte-enable single-port RAM with a registered read.
// Ports:
//   clk_i    clock
//   we_i     write strobe; lanes selected by be_i are written at addr_i
//   re_i     read strobe; rdata_o loads word at addr_i on the same edge
//   addr_i   word address (shared by read and write)
//   wdata_i  write data
//   be_i     per-lane write enable
//   rdata_o  registered read data, holds between reads
module module_memory_array
  import memory_defs::*;
#(
  parameter int unsigned DATA_LENGTH = 8,
  parameter int unsigned ADDR_LENGTH = 4,
  parameter int unsigned BYTE_LENGTH = 8
) (
  input  logic                                          clk_i,
  input  logic                                          we_i,
  input  logic                                          re_i,
  input  logic [ADDR_LENGTH-1:0]                        addr_i,
  input  logic [DATA_LENGTH-1:0]                        wdata_i,
  input  logic [lanes_of(DATA_LENGTH, BYTE_LENGTH)-1:0] be_i,
  output logic [DATA_LENGTH-1:0]                        rdata_o
);

  localparam int unsigned LANES = lanes_of(DATA_LENGTH, BYTE_LENGTH);
  localparam int unsigned DEPTH = 2 ** ADDR_LENGTH;

  logic [DATA_LENGTH-1:0] mem_q [DEPTH];
  logic [DATA_LENGTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (be_i[i]) begin
          mem_q[addr_i][i*BYTE_LENGTH +: BYTE_LENGTH] <= wdata_i[i*BYTE_LENGTH +: BYTE_LENGTH];
        end
      end
    end
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/module_memory_ctrl.sv
// Memory controller: single-port RAM behind a req/ready handshake, with
// byte-lane writes, read latency of 1 or 2 and an optional post-reset sweep
// that writes CLEAR_VALUE to every word.
// Ports:
//   clk         clock, rising edge
//   rst_n       synchronous active-low reset
//   req         request strobe, accepted when req && ready
//   ready       request can be accepted this cycle
//   read_write  1 = write, 0 = read
//   address     word address
//   data_in     write data
//   byte_en     per-lane write enable (writes only)
//   data_out    read data, holds last result
//   data_valid  one-cycle pulse per read result
//   init_done   sticky, set once the controller is in service
module module_memory_ctrl
  import memory_defs::*;
#(
  parameter int unsigned            DATA_LENGTH    = 8,
  parameter int unsigned            ADDR_LENGTH    = 4,
  parameter int unsigned            BYTE_LENGTH    = 8,
  parameter int unsigned            READ_LATENCY   = 1,
  parameter bit                     CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_LENGTH-1:0] CLEAR_VALUE    = '0
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          req,
  output logic                                          ready,
  input  logic                                          read_write,
  input  logic [ADDR_LENGTH-1:0]                        address,
  input  logic [DATA_LENGTH-1:0]                        data_in,
  input  logic [lanes_of(DATA_LENGTH, BYTE_LENGTH)-1:0] byte_en,
  output logic [DATA_LENGTH-1:0]                        data_out,
  output logic                                          data_valid,
  output logic                                          init_done
);

  localparam int unsigned LANES = lanes_of(DATA_LENGTH, BYTE_LENGTH);
  localparam int unsigned DEPTH = 2 ** ADDR_LENGTH;
  localparam logic [ADDR_LENGTH:0] CLR_LAST = (ADDR_LENGTH + 1)'(DEPTH - 1);
  localparam state_e RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;

  if (!params_legal(DATA_LENGTH, BYTE_LENGTH, READ_LATENCY)) begin : g_param_check
    $error("module_memory_ctrl: illegal DATA_LENGTH/BYTE_LENGTH/READ_LATENCY combination");
  end

  state_e                 state_q, state_d;
  logic [ADDR_LENGTH:0]   clr_addr_q, clr_addr_d;
  logic                   ready_q, init_done_q;
  logic                   accept, rd_accept, wr_accept;

  logic                   arr_we, arr_re;
  logic [ADDR_LENGTH-1:0] arr_addr;
  logic [DATA_LENGTH-1:0] arr_wdata, arr_rdata;
  logic [LANES-1:0]       arr_be;

  logic                   rd_valid_q;
  logic                   pres_valid;
  logic [DATA_LENGTH-1:0] pres_data;
  logic [DATA_LENGTH-1:0] data_out_q;
  logic                   data_valid_q;

  // rst_n gates acceptance so nothing touches the array on a reset edge.
  assign accept    = req & ready_q & rst_n;
  assign rd_accept = accept & ~read_write;
  assign wr_accept = accept & read_write;

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    arr_we     = wr_accept;
    arr_re     = rd_accept;
    arr_addr   = address;
    arr_wdata  = data_in;
    arr_be     = byte_en;
    case (state_q)
      ST_CLEAR: begin
        // Sweep owns the single write port; ready is low so no user access.
        arr_we     = rst_n;
        arr_re     = 1'b0;
        arr_addr   = clr_addr_q[ADDR_LENGTH-1:0];
        arr_wdata  = CLEAR_VALUE;
        arr_be     = '1;
        clr_addr_d = clr_addr_q + (ADDR_LENGTH + 1)'(1);
        if (clr_addr_q == CLR_LAST) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= RESET_STATE;
      clr_addr_q   <= '0;
      ready_q      <= 1'b0;
      init_done_q  <= 1'b0;
      rd_valid_q   <= 1'b0;
      data_valid_q <= 1'b0;
      data_out_q   <= '0;
    end else begin
      state_q      <= state_d;
      clr_addr_q   <= clr_addr_d;
      ready_q      <= (state_d == ST_RUN);
      init_done_q  <= init_done_q | (state_d == ST_RUN);
      rd_valid_q   <= rd_accept;
      data_valid_q <= pres_valid;
      if (pres_valid) begin
        data_out_q <= pres_data;
      end
    end
  end

  // Array output register is stage 0; latency 2 inserts one more stage
  // before the data_out register.
  if (READ_LATENCY == 2) begin : g_lat2
    logic                   stage_valid_q;
    logic [DATA_LENGTH-1:0] stage_data_q;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        stage_valid_q <= 1'b0;
      end else begin
        stage_valid_q <= rd_valid_q;
        if (rd_valid_q) begin
          stage_data_q <= arr_rdata;
        end
      end
    end

    assign pres_valid = stage_valid_q;
    assign pres_data  = stage_data_q;
  end else begin : g_lat1
    assign pres_valid = rd_valid_q;
    assign pres_data  = arr_rdata;
  end

  module_memory_array #(
    .DATA_LENGTH(DATA_LENGTH),
    .ADDR_LENGTH(ADDR_LENGTH),
    .BYTE_LENGTH(BYTE_LENGTH)
  ) u_array (
    .clk_i  (clk),
    .we_i   (arr_we),
    .re_i   (arr_re),
    .addr_i (arr_addr),
    .wdata_i(arr_wdata),
    .be_i   (arr_be),
    .rdata_o(arr_rdata)
  );

  assign ready      = ready_q;
  assign init_done  = init_done_q;
  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;

endmodule

// File: tb/tb_module_memory_ctrl.sv
module tb_module_memory_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned ec = 0;
  always @(posedge clk) ec <= ec + 1;

  int errors = 0;
  int checks = 0;

  // u0: default parameters
  logic        rst0_n = 1'b0, req0 = 1'b0, rw0 = 1'b0;
  logic [3:0]  addr0 = '0;
  logic [7:0]  din0 = '0;
  logic [0:0]  be0 = '0;
  logic        rdy0, dv0, idone0;
  logic [7:0]  dout0;

  // u1: 16-bit words, latency 2, no sweep
  logic        rst1_n = 1'b0, req1 = 1'b0, rw1 = 1'b0;
  logic [3:0]  addr1 = '0;
  logic [15:0] din1 = '0;
  logic [1:0]  be1 = '0;
  logic        rdy1, dv1, idone1;
  logic [15:0] dout1;

  module_memory_ctrl #(
    .DATA_LENGTH(8), .ADDR_LENGTH(4), .BYTE_LENGTH(8),
    .READ_LATENCY(1), .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(8'h00)
  ) u0 (
    .clk(clk), .rst_n(rst0_n), .req(req0), .ready(rdy0), .read_write(rw0),
    .address(addr0), .data_in(din0), .byte_en(be0), .data_out(dout0),
    .data_valid(dv0), .init_done(idone0)
  );

  module_memory_ctrl #(
    .DATA_LENGTH(16), .ADDR_LENGTH(4), .BYTE_LENGTH(8),
    .READ_LATENCY(2), .CLEAR_ON_RESET(1'b0), .CLEAR_VALUE(16'h0000)
  ) u1 (
    .clk(clk), .rst_n(rst1_n), .req(req1), .ready(rdy1), .read_write(rw1),
    .address(addr1), .data_in(din1), .byte_en(be1), .data_out(dout1),
    .data_valid(dv1), .init_done(idone1)
  );

  // Reference model: word arrays plus expected (cycle, data) read results.
  typedef struct {
    int unsigned cyc;
    logic [15:0] data;
  } rd_t;

  rd_t         obs0[$], exp0[$], obs1[$], exp1[$];
  logic [7:0]  m0[16];
  logic [15:0] m1[16];
  bit          rdy_m0 = 1'b0, rdy_m1 = 1'b0;

  always @(negedge clk) begin
    if (dv0 === 1'b1) obs0.push_back(rd_t'{ec, {8'h00, dout0}});
    if (dv1 === 1'b1) obs1.push_back(rd_t'{ec, dout1});
  end

  task automatic op0(input bit en, input bit wr, input logic [3:0] a,
                     input logic [7:0] d, input logic be);
    req0 = en; rw0 = wr; addr0 = a; din0 = d; be0 = be;
    @(posedge clk); #1;
    if (en && rdy_m0) begin
      if (wr) begin
        if (be) m0[a] = d;
      end else begin
        exp0.push_back(rd_t'{ec + 1, {8'h00, m0[a]}});
      end
    end
    req0 = 1'b0;
  endtask

  task automatic op1(input bit en, input bit wr, input logic [3:0] a,
                     input logic [15:0] d, input logic [1:0] be);
    req1 = en; rw1 = wr; addr1 = a; din1 = d; be1 = be;
    @(posedge clk); #1;
    if (en && rdy_m1) begin
      if (wr) begin
        for (int i = 0; i < 2; i++) if (be[i]) m1[a][8*i +: 8] = d[8*i +: 8];
      end else begin
        exp1.push_back(rd_t'{ec + 2, m1[a]});
      end
    end
    req1 = 1'b0;
  endtask

  task automatic test_reset();
    rst0_n = 1'b0; rst1_n = 1'b0;
    repeat (2) @(posedge clk); #1;
    checks++; if (rdy0 !== 1'b0)    begin errors++; $display("FAIL reset_ready0: got %b need 0", rdy0); end
    checks++; if (dv0 !== 1'b0)     begin errors++; $display("FAIL reset_valid0: got %b need 0", dv0); end
    checks++; if (dout0 !== 8'h00)  begin errors++; $display("FAIL reset_dout0: got %h need 00", dout0); end
    checks++; if (idone0 !== 1'b0)  begin errors++; $display("FAIL reset_idone0: got %b need 0", idone0); end
    checks++; if (rdy1 !== 1'b0)    begin errors++; $display("FAIL reset_ready1: got %b need 0", rdy1); end
    checks++; if (dout1 !== 16'h0)  begin errors++; $display("FAIL reset_dout1: got %h need 0000", dout1); end
    rst0_n = 1'b1; rst1_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      checks++;
      if (rdy0 !== 1'b0 || idone0 !== 1'b0) begin
        errors++; $display("FAIL sweep_ready0[%0d]: got rdy=%b idone=%b need 0/0", i, rdy0, idone0);
      end
      if (i == 1) begin
        checks++;
        if (rdy1 !== 1'b1 || idone1 !== 1'b1) begin
          errors++; $display("FAIL noclr_ready1: got rdy=%b idone=%b need 1/1", rdy1, idone1);
        end
      end
    end
    @(negedge clk);
    checks++;
    if (rdy0 !== 1'b1 || idone0 !== 1'b1) begin
      errors++; $display("FAIL run_ready0: got rdy=%b idone=%b need 1/1", rdy0, idone0);
    end
    rdy_m0 = 1'b1; rdy_m1 = 1'b1;
    foreach (m0[i]) m0[i] = 8'h00;
    obs0.delete(); obs1.delete();
    op0(1'b1, 1'b0, 4'd5, 8'h00, 1'b0);
    repeat (5) @(negedge clk); #1;
    checks++;
    if (obs0.size() != exp0.size()) begin errors++; $display("FAIL reset_rd_count0: got %0d need %0d", obs0.size(), exp0.size()); end
    for (int i = 0; i < exp0.size() && i < obs0.size(); i++) begin
      checks++;
      if (obs0[i].cyc !== exp0[i].cyc || obs0[i].data !== exp0[i].data) begin
        errors++; $display("FAIL reset_rd0[%0d]: got cyc %0d data %h need cyc %0d data %h",
                           i, obs0[i].cyc, obs0[i].data, exp0[i].cyc, exp0[i].data);
      end
    end
    obs0.delete(); exp0.delete();
  endtask

  task automatic test_write_read();
    logic [3:0] a;
    op0(1'b1, 1'b1, 4'd3, 8'hA5, 1'b1);
    op0(1'b1, 1'b0, 4'd3, 8'h00, 1'b0);
    for (int i = 0; i < 6; i++) begin
      a = 4'($urandom_range(15));
      op0(1'b1, 1'b1, a, 8'($urandom), 1'($urandom_range(1)));
      op0(1'b1, 1'b0, a, 8'h00, 1'b0);
    end
    op1(1'b1, 1'b1, 4'd7, 16'hFFFF, 2'b11);
    op1(1'b1, 1'b1, 4'd7, 16'h1234, 2'b01);
    op1(1'b1, 1'b0, 4'd7, 16'h0000, 2'b00);
    for (int i = 0; i < 6; i++) begin
      a = 4'($urandom_range(15));
      op1(1'b1, 1'b1, a, 16'($urandom), 2'b11);
      op1(1'b1, 1'b1, a, 16'($urandom), 2'($urandom_range(3)));
      op1(1'b1, 1'b0, a, 16'h0000, 2'b00);
    end
    repeat (5) @(negedge clk); #1;
    checks++;
    if (obs0.size() != exp0.size()) begin errors++; $display("FAIL wr_rd_count0: got %0d need %0d", obs0.size(), exp0.size()); end
    for (int i = 0; i < exp0.size() && i < obs0.size(); i++) begin
      checks++;
      if (obs0[i].cyc !== exp0[i].cyc || obs0[i].data !== exp0[i].data) begin
        errors++; $display("FAIL wr_rd0[%0d]: got cyc %0d data %h need cyc %0d data %h",
                           i, obs0[i].cyc, obs0[i].data, exp0[i].cyc, exp0[i].data);
      end
    end
    checks++;
    if (obs1.size() != exp1.size()) begin errors++; $display("FAIL wr_rd_count1: got %0d need %0d", obs1.size(), exp1.size()); end
    for (int i = 0; i < exp1.size() && i < obs1.size(); i++) begin
      checks++;
      if (obs1[i].cyc !== exp1[i].cyc || obs1[i].data !== exp1[i].data) begin
        errors++; $display("FAIL wr_rd1[%0d]: got cyc %0d data %h need cyc %0d data %h",
                           i, obs1[i].cyc, obs1[i].data, exp1[i].cyc, exp1[i].data);
      end
    end
    obs0.delete(); exp0.delete(); obs1.delete(); exp1.delete();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) op0(1'b1, 1'b1, 4'(i), 8'(i) ^ 8'h5A, 1'b1);
    for (int i = 0; i < 16; i++) op0(1'b1, 1'b0, 4'(i), 8'h00, 1'b0);
    for (int i = 0; i < 16; i++) op1(1'b1, 1'b1, 4'(i), 16'(i) ^ 16'h005A, 2'b11);
    for (int i = 0; i < 16; i++) op1(1'b1, 1'b0, 4'(i), 16'h0000, 2'b00);
    for (int i = 0; i < 30; i++) begin
      op0($urandom_range(3) != 0, 1'($urandom_range(1)), 4'($urandom_range(15)),
          8'($urandom), 1'($urandom_range(1)));
    end
    for (int i = 0; i < 30; i++) begin
      op1($urandom_range(3) != 0, 1'($urandom_range(1)), 4'($urandom_range(15)),
          16'($urandom), 2'($urandom_range(3)));
    end
    repeat (5) @(negedge clk); #1;
    checks++;
    if (obs0.size() != exp0.size()) begin errors++; $display("FAIL b2b_count0: got %0d need %0d", obs0.size(), exp0.size()); end
    for (int i = 0; i < exp0.size() && i < obs0.size(); i++) begin
      checks++;
      if (obs0[i].cyc !== exp0[i].cyc || obs0[i].data !== exp0[i].data) begin
        errors++; $display("FAIL b2b_rd0[%0d]: got cyc %0d data %h need cyc %0d data %h",
                           i, obs0[i].cyc, obs0[i].data, exp0[i].cyc, exp0[i].data);
      end
    end
    checks++;
    if (obs1.size() != exp1.size()) begin errors++; $display("FAIL b2b_count1: got %0d need %0d", obs1.size(), exp1.size()); end
    for (int i = 0; i < exp1.size() && i < obs1.size(); i++) begin
      checks++;
      if (obs1[i].cyc !== exp1[i].cyc || obs1[i].data !== exp1[i].data) begin
        errors++; $display("FAIL b2b_rd1[%0d]: got cyc %0d data %h need cyc %0d data %h",
                           i, obs1[i].cyc, obs1[i].data, exp1[i].cyc, exp1[i].data);
      end
    end
    obs0.delete(); exp0.delete(); obs1.delete(); exp1.delete();
  endtask

  task automatic test_reset_mid_sweep();
    for (int i = 0; i < 16; i++) op0(1'b1, 1'b1, 4'(i), 8'(i) ^ 8'h5A, 1'b1);
    rst0_n = 1'b0; rdy_m0 = 1'b0;
    @(posedge clk); #1;
    rst0_n = 1'b1;
    repeat (7) @(posedge clk); #1;
    rst0_n = 1'b0;
    @(posedge clk); #1;
    rst0_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      checks++;
      if (rdy0 !== 1'b0) begin errors++; $display("FAIL resweep_ready0[%0d]: got %b need 0", i, rdy0); end
    end
    @(negedge clk);
    checks++;
    if (rdy0 !== 1'b1) begin errors++; $display("FAIL resweep_run0: got %b need 1", rdy0); end
    rdy_m0 = 1'b1;
    foreach (m0[i]) m0[i] = 8'h00;
    for (int i = 0; i < 16; i++) op0(1'b1, 1'b0, 4'(i), 8'h00, 1'b0);
    repeat (5) @(negedge clk); #1;
    checks++;
    if (obs0.size() != exp0.size()) begin errors++; $display("FAIL resweep_count0: got %0d need %0d", obs0.size(), exp0.size()); end
    for (int i = 0; i < exp0.size() && i < obs0.size(); i++) begin
      checks++;
      if (obs0[i].cyc !== exp0[i].cyc || obs0[i].data !== exp0[i].data) begin
        errors++; $display("FAIL resweep_rd0[%0d]: got cyc %0d data %h need cyc %0d data %h",
                           i, obs0[i].cyc, obs0[i].data, exp0[i].cyc, exp0[i].data);
      end
    end
    obs0.delete(); exp0.delete();
  endtask

  task automatic test_req_during_sweep();
    rst0_n = 1'b0; rdy_m0 = 1'b0;
    @(posedge clk); #1;
    rst0_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) op0(1'b1, 1'b1, 4'd2, 8'h77, 1'b1);
      else            op0(1'b1, (i == 15), 4'($urandom_range(15)), 8'h77, 1'b1);
    end
    rdy_m0 = 1'b1;
    foreach (m0[i]) m0[i] = 8'h00;
    op0(1'b1, 1'b0, 4'd2, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) op0(1'b1, 1'b0, 4'($urandom_range(15)), 8'h00, 1'b0);
    repeat (5) @(negedge clk); #1;
    checks++;
    if (obs0.size() != exp0.size()) begin errors++; $display("FAIL sweepreq_count0: got %0d need %0d", obs0.size(), exp0.size()); end
    for (int i = 0; i < exp0.size() && i < obs0.size(); i++) begin
      checks++;
      if (obs0[i].cyc !== exp0[i].cyc || obs0[i].data !== exp0[i].data) begin
        errors++; $display("FAIL sweepreq_rd0[%0d]: got cyc %0d data %h need cyc %0d data %h",
                           i, obs0[i].cyc, obs0[i].data, exp0[i].cyc, exp0[i].data);
      end
    end
    obs0.delete(); exp0.delete();
  endtask

  task automatic test_reset_inflight();
    op0(1'b1, 1'b1, 4'd9, 8'h3C, 1'b1);
    op0(1'b1, 1'b0, 4'd9, 8'h00, 1'b0);
    op0(1'b1, 1'b0, 4'd9, 8'h00, 1'b0);
    void'(exp0.pop_back());
    rst0_n = 1'b0; rdy_m0 = 1'b0;
    @(posedge clk); #1;
    checks++; if (dv0 !== 1'b0)    begin errors++; $display("FAIL inflight_valid: got %b need 0", dv0); end
    checks++; if (dout0 !== 8'h00) begin errors++; $display("FAIL inflight_dout: got %h need 00", dout0); end
    @(posedge clk); #1;
    rst0_n = 1'b1;
    repeat (17) @(posedge clk); #1;
    rdy_m0 = 1'b1;
    repeat (5) @(negedge clk); #1;
    checks++; if (dout0 !== 8'h00) begin errors++; $display("FAIL inflight_dout_after: got %h need 00", dout0); end
    checks++;
    if (obs0.size() != exp0.size()) begin errors++; $display("FAIL inflight_count0: got %0d need %0d", obs0.size(), exp0.size()); end
    for (int i = 0; i < exp0.size() && i < obs0.size(); i++) begin
      checks++;
      if (obs0[i].cyc !== exp0[i].cyc || obs0[i].data !== exp0[i].data) begin
        errors++; $display("FAIL inflight_rd0[%0d]: got cyc %0d data %h need cyc %0d data %h",
                           i, obs0[i].cyc, obs0[i].data, exp0[i].cyc, exp0[i].data);
      end
    end
    obs0.delete(); exp0.delete();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_reset_mid_sweep();
    test_req_during_sweep();
    test_reset_inflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
